// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: dual-channel servo PWM generator with frame-aligned
// command latching. A prescaler builds a microsecond tick, a microsecond
// counter spans one frame, and each channel compares the counter against a
// shadow width register that only changes at frame boundaries (or freely
// while disabled). Optional macro SERVO_SLEW_EN limits how far each shadow
// may move per frame.
module servo_pwm_driver #(
    parameter int CLK_PER_US   = 50,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 200,
    parameter int MAX_PULSE_US = 2500,
    parameter int PAN_INIT_US  = 500,
    parameter int TILT_INIT_US = 590,
    parameter int MAX_STEP_US  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] pan,
    input  logic [10:0] tilt,
    output logic        pan_ready,
    output logic        tilt_ready,
    output logic        pan_pwm,
    output logic        tilt_pwm,
    output logic        frame_start
);

    localparam int PRESC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_US - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);
    localparam logic [14:0]        US_LAST    = 15'(PERIOD_US - 1);
    localparam logic [14:0]        US_ONE     = 15'd1;
    localparam logic [14:0]        US_ZERO    = 15'd0;
    // Widths are carried at counter width so compares never truncate
    // (MAX_PULSE_US may exceed the 11-bit command range).
    localparam logic [14:0]        MIN_W      = 15'(MIN_PULSE_US);
    localparam logic [14:0]        MAX_W      = 15'(MAX_PULSE_US);
    localparam logic [14:0]        PAN_INIT_W = 15'(PAN_INIT_US);
    localparam logic [14:0]        TILT_INIT_W = 15'(TILT_INIT_US);

    // Saturate a raw command into the legal pulse window.
    function automatic logic [14:0] clamp_width(input logic [10:0] v);
        logic [14:0] w;
        w = {4'd0, v};
        if (w < MIN_W) begin
            clamp_width = MIN_W;
        end else if (w > MAX_W) begin
            clamp_width = MAX_W;
        end else begin
            clamp_width = w;
        end
    endfunction

`ifdef SERVO_SLEW_EN
    localparam logic [14:0] STEP_W = 15'(MAX_STEP_US);

    // Move cur toward tgt by at most STEP_W, landing exactly on tgt when close.
    function automatic logic [14:0] slew_step(input logic [14:0] cur,
                                              input logic [14:0] tgt);
        if (tgt > cur) begin
            if ((tgt - cur) > STEP_W) begin
                slew_step = cur + STEP_W;
            end else begin
                slew_step = tgt;
            end
        end else begin
            if ((cur - tgt) > STEP_W) begin
                slew_step = cur - STEP_W;
            end else begin
                slew_step = tgt;
            end
        end
    endfunction
`endif

    logic [PRESC_W-1:0] presc_r;
    logic [14:0]        us_cnt_r;
    logic [14:0]        pan_sh_r;
    logic [14:0]        tilt_sh_r;
    logic               pan_pwm_r;
    logic               tilt_pwm_r;
    logic               pan_ready_r;
    logic               tilt_ready_r;
    logic               frame_start_r;

    logic               tick_s;
    logic               boundary_s;
    logic               ready_hit_s;
    logic               start_hit_s;
    logic [14:0]        pan_tgt_s;
    logic [14:0]        tilt_tgt_s;
    logic [14:0]        pan_next_s;
    logic [14:0]        tilt_next_s;

    // Timebase decodes and the shadow values to adopt at the next boundary.
    always_comb begin
        tick_s      = (presc_r == PRESC_LAST);
        boundary_s  = tick_s && (us_cnt_r == US_LAST);
        ready_hit_s = (us_cnt_r == US_LAST) && (presc_r == PRESC_ZERO);
        start_hit_s = (us_cnt_r == US_ZERO) && (presc_r == PRESC_ZERO);
        pan_tgt_s   = clamp_width(pan);
        tilt_tgt_s  = clamp_width(tilt);
`ifdef SERVO_SLEW_EN
        pan_next_s  = slew_step(pan_sh_r, pan_tgt_s);
        tilt_next_s = slew_step(tilt_sh_r, tilt_tgt_s);
`else
        pan_next_s  = pan_tgt_s;
        tilt_next_s = tilt_tgt_s;
`endif
    end

    // Prescaler and microsecond counter; parked at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r  <= PRESC_ZERO;
            us_cnt_r <= US_ZERO;
        end else if (!en) begin
            presc_r  <= PRESC_ZERO;
            us_cnt_r <= US_ZERO;
        end else if (tick_s) begin
            presc_r  <= PRESC_ZERO;
            us_cnt_r <= (us_cnt_r == US_LAST) ? US_ZERO : (us_cnt_r + US_ONE);
        end else begin
            presc_r  <= presc_r + PRESC_ONE;
            us_cnt_r <= us_cnt_r;
        end
    end

    // Shadow widths: track commands while disabled, otherwise change only at frame boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pan_sh_r  <= PAN_INIT_W;
            tilt_sh_r <= TILT_INIT_W;
        end else if (!en) begin
            pan_sh_r  <= pan_tgt_s;
            tilt_sh_r <= tilt_tgt_s;
        end else if (boundary_s) begin
            pan_sh_r  <= pan_next_s;
            tilt_sh_r <= tilt_next_s;
        end else begin
            pan_sh_r  <= pan_sh_r;
            tilt_sh_r <= tilt_sh_r;
        end
    end

    // Registered PWM compares and strobes, one cycle behind the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pan_pwm_r     <= 1'b0;
            tilt_pwm_r    <= 1'b0;
            pan_ready_r   <= 1'b0;
            tilt_ready_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (!en) begin
            pan_pwm_r     <= 1'b0;
            tilt_pwm_r    <= 1'b0;
            pan_ready_r   <= 1'b0;
            tilt_ready_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            pan_pwm_r     <= (us_cnt_r < pan_sh_r);
            tilt_pwm_r    <= (us_cnt_r < tilt_sh_r);
            pan_ready_r   <= ready_hit_s;
            tilt_ready_r  <= ready_hit_s;
            frame_start_r <= start_hit_s;
        end
    end

    assign pan_pwm     = pan_pwm_r;
    assign tilt_pwm    = tilt_pwm_r;
    assign pan_ready   = pan_ready_r;
    assign tilt_ready  = tilt_ready_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Testbench for servo_pwm_driver with a 4-cycle microsecond and a 100 us
// frame. Expected pulse widths are pushed to a queue when commands are
// driven and popped when the measured frame completes. Building with
// SERVO_SLEW_EN runs the slew sequence instead of the jump sequence.
module tb_servo_pwm_driver;

    localparam int CPU   = 4;
    localparam int PER   = 100;
    localparam int FRAME = CPU * PER;
    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] pan;
    logic [10:0] tilt;
    logic        pan_ready;
    logic        tilt_ready;
    logic        pan_pwm;
    logic        tilt_pwm;
    logic        frame_start;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int pan_cyc;
        int tilt_cyc;
    } exp_t;

    typedef struct {
        logic [10:0] pan;
        logic [10:0] tilt;
        int          pan_cyc;
        int          tilt_cyc;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];

    servo_pwm_driver #(
        .CLK_PER_US  (CPU),
        .PERIOD_US   (PER),
        .MIN_PULSE_US(10),
        .MAX_PULSE_US(80),
        .PAN_INIT_US (50),
        .TILT_INIT_US(59),
        .MAX_STEP_US (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pan        (pan),
        .tilt       (tilt),
        .pan_ready  (pan_ready),
        .tilt_ready (tilt_ready),
        .pan_pwm    (pan_pwm),
        .tilt_pwm   (tilt_pwm),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push_exp(input int p, input int t);
        exp_t e;
        e.pan_cyc  = p;
        e.tilt_cyc = t;
        exp_q.push_back(e);
    endtask

    // Wait for the ready strobe; both channels must strobe together.
    task automatic wait_ready(input string name);
        int found = 0;
        for (int i = 0; i < BUDGET && found == 0; i++) begin
            @(negedge clk);
            if (pan_ready) found = 1;
        end
        check({name, "_ready_seen"}, found, 1);
        if (found == 1) check({name, "_tilt_ready"}, int'(tilt_ready), 1);
    endtask

    // Wait for frame_start and check how many cycles it took.
    task automatic wait_fs(input string name, input int exp_lat);
        int found = 0;
        int lat = 0;
        for (int i = 0; i < BUDGET && found == 0; i++) begin
            @(negedge clk);
            lat++;
            if (frame_start) found = 1;
        end
        check({name, "_fs_seen"}, found, 1);
        if (found == 1) check({name, "_fs_latency"}, lat, exp_lat);
    endtask

    // Measure one frame starting at a frame_start sample; optionally change pan mid-frame.
    task automatic measure_frame(input string name, input int chg_idx,
                                 input logic [10:0] chg_pan);
        exp_t e;
        int pc = 0;
        int tc = 0;
        int rdy = -1;
        int trdy = -1;
        int extra = 0;
        check({name, "_rise"}, int'(pan_pwm & tilt_pwm), 1);
        for (int i = 0; i < FRAME; i++) begin
            if (i == chg_idx) pan = chg_pan;
            if (pan_pwm) pc++;
            if (tilt_pwm) tc++;
            if (pan_ready) begin
                if (rdy < 0) rdy = i;
                else extra++;
            end
            if (tilt_ready) begin
                if (trdy < 0) trdy = i;
                else extra++;
            end
            if (frame_start && i != 0) extra++;
            @(negedge clk);
        end
        check({name, "_period"}, int'(frame_start), 1);
        check({name, "_ready_pos"}, rdy, FRAME - CPU);
        check({name, "_tready_pos"}, trdy, FRAME - CPU);
        check({name, "_extra_strobes"}, extra, 0);
        if (exp_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({name, "_pan_width"}, pc, e.pan_cyc);
            check({name, "_tilt_width"}, tc, e.tilt_cyc);
        end
    endtask

    initial begin
        int any;
        vecs[0] = '{11'd30, 11'd59,   120, 236};
        vecs[1] = '{11'd5,  11'd2000, 40,  320};
        vecs[2] = '{11'd80, 11'd81,   320, 320};
        vecs[3] = '{11'd10, 11'd9,    40,  40};
        vecs[4] = '{11'd0,  11'd2047, 40,  320};
        vecs[5] = '{11'd50, 11'd59,   200, 236};

        rst  = 1'b1;
        en   = 1'b0;
        pan  = 11'd50;
        tilt = 11'd59;
        repeat (3) @(negedge clk);
        check("rst_pan_pwm", int'(pan_pwm), 0);
        check("rst_tilt_pwm", int'(tilt_pwm), 0);
        check("rst_pan_ready", int'(pan_ready), 0);
        check("rst_tilt_ready", int'(tilt_ready), 0);
        check("rst_frame_start", int'(frame_start), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("dis_idle", int'(pan_pwm | tilt_pwm | frame_start | pan_ready), 0);

        en = 1'b1;
        wait_fs("init", 1);
        push_exp(200, 236);
        measure_frame("init", -1, 11'd0);

`ifdef SERVO_SLEW_EN
        wait_ready("slew");
        @(negedge clk);
        pan = 11'd70;
        wait_fs("slew", 3);
        push_exp(220, 236);
        measure_frame("slew55", -1, 11'd0);
        push_exp(240, 236);
        measure_frame("slew60", -1, 11'd0);
        push_exp(260, 236);
        measure_frame("slew65", -1, 11'd0);
        push_exp(280, 236);
        measure_frame("slew70", -1, 11'd0);
        push_exp(280, 236);
        measure_frame("slew_steady", -1, 11'd0);
`else
        // Commands applied one cycle after the ready strobe take effect next frame.
        for (int v = 0; v < 6; v++) begin
            wait_ready($sformatf("vec%0d", v));
            @(negedge clk);
            pan  = vecs[v].pan;
            tilt = vecs[v].tilt;
            push_exp(vecs[v].pan_cyc, vecs[v].tilt_cyc);
            wait_fs($sformatf("vec%0d", v), 3);
            measure_frame($sformatf("vec%0d", v), -1, 11'd0);
        end

        // Command change mid-pulse: current pulse keeps the old width.
        push_exp(200, 236);
        measure_frame("midpulse", 80, 11'd30);
        push_exp(120, 236);
        measure_frame("after_mid", -1, 11'd0);

        // Disable mid-pulse, then re-enable with a new command.
        repeat (40) @(negedge clk);
        check("pre_drop_high", int'(pan_pwm), 1);
        en  = 1'b0;
        pan = 11'd60;
        @(negedge clk);
        check("drop_pwm_low", int'(pan_pwm | tilt_pwm), 0);
        any = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pan_pwm | tilt_pwm | pan_ready | tilt_ready | frame_start) any++;
        end
        check("dis_quiet", any, 0);
        en = 1'b1;
        wait_fs("reen", 1);
        push_exp(240, 236);
        measure_frame("reen", -1, 11'd0);

        // Reset mid-pulse: outputs drop at once, shadows return to init.
        pan  = 11'd70;
        tilt = 11'd70;
        repeat (40) @(negedge clk);
        check("pre_rst_high", int'(pan_pwm), 1);
        rst = 1'b1;
        #1;
        check("rst_async_pan", int'(pan_pwm), 0);
        check("rst_async_tilt", int'(tilt_pwm), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_fs("post_rst", 1);
        push_exp(200, 236);
        measure_frame("post_rst", -1, 11'd0);
        push_exp(280, 280);
        measure_frame("post_rst_load", -1, 11'd0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
